// File: rtl/gpu_clock_monitor.sv
// gpu_clock_monitor
//   Receive-side health checker for a divided GPU clock. mon_clk is sampled
//   as data in the clk_in domain. Each period and high time is measured in
//   clk_in cycles. Lock is declared after LOCK_COUNT consecutive good
//   periods. A sticky fault is raised on a bad period or a stopped clock
//   while locked.
// Ports
//   clk_in        sole clock
//   rst           asynchronous active-high reset
//   mon_clk       divided clock under test (asynchronous, synchronized here)
//   clear         synchronous return to IDLE; clears fault/stuck/counters
//   locked        1 while in LOCKED
//   fault         1 while in FAULT (sticky until clear)
//   stuck         fault was caused by a timeout
//   period_valid  one-cycle pulse when period/high_time update
//   period        last measured period in clk_in cycles
//   high_time     last measured high time in clk_in cycles
module gpu_clock_monitor #(
   parameter int EXPECTED_DIV = 4,
   parameter int TOLERANCE    = 0,
   parameter int LOCK_COUNT   = 4,
   parameter int TIMEOUT      = 4*EXPECTED_DIV,
   localparam int CNT_W       = $clog2(TIMEOUT+1)
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             mon_clk,
   input  logic             clear,
   output logic             locked,
   output logic             fault,
   output logic             stuck,
   output logic             period_valid,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time
);

   localparam int GC_W = $clog2(LOCK_COUNT+1);

   generate
      if ((EXPECTED_DIV % 2) != 0 || EXPECTED_DIV < 2 || LOCK_COUNT < 1 ||
          TIMEOUT <= EXPECTED_DIV) begin : g_param_check
         $fatal(1, "gpu_clock_monitor: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

   state_t            state;
   logic              sync1, sync2, edge_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  hi_cap;
   logic [GC_W-1:0]   good_cnt;
   logic              rise, fall, timeout, good;

   function automatic logic in_tol(input int v, input int e);
      return (v >= e - TOLERANCE) && (v <= e + TOLERANCE);
   endfunction

   assign rise    = sync2 & ~edge_q;
   assign fall    = ~sync2 & edge_q;
   // A rise in the same cycle as saturation restarts the count, so it wins.
   assign timeout = (cnt == CNT_W'(TIMEOUT)) && !rise;
   // Judged on the values being captured into period/high_time this cycle.
   assign good    = in_tol(int'(cnt), EXPECTED_DIV) &&
                    in_tol(int'(hi_cap), EXPECTED_DIV/2);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         edge_q       <= 1'b0;
         state        <= IDLE;
         cnt          <= '0;
         hi_cap       <= '0;
         good_cnt     <= '0;
         locked       <= 1'b0;
         fault        <= 1'b0;
         stuck        <= 1'b0;
         period_valid <= 1'b0;
         period       <= '0;
         high_time    <= '0;
      end else begin
         // Synchronizer keeps running through clear so edges stay coherent.
         sync1        <= mon_clk;
         sync2        <= sync1;
         edge_q       <= sync2;
         period_valid <= 1'b0;
         if (clear) begin
            state    <= IDLE;
            good_cnt <= '0;
            cnt      <= '0;
            stuck    <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b0;
         end else begin
            if (rise)
               cnt <= CNT_W'(1);
            else if (cnt != CNT_W'(TIMEOUT))
               cnt <= cnt + CNT_W'(1);

            // Leaving IDLE doubles as the "seen a first rise" flag.
            if (fall && state != IDLE)
               hi_cap <= cnt;
            if (rise && state != IDLE) begin
               period       <= cnt;
               high_time    <= hi_cap;
               period_valid <= 1'b1;
            end

            case (state)
               IDLE: begin
                  if (rise) begin
                     state    <= ACQUIRE;
                     good_cnt <= '0;
                  end
               end
               ACQUIRE: begin
                  if (rise) begin
                     if (good) begin
                        good_cnt <= good_cnt + GC_W'(1);
                        if (good_cnt == GC_W'(LOCK_COUNT-1)) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end else begin
                        good_cnt <= '0;
                     end
                  end else if (timeout) begin
                     state <= IDLE;
                  end
               end
               LOCKED: begin
                  if (rise && !good) begin
                     state  <= FAULT;
                     locked <= 1'b0;
                     fault  <= 1'b1;
                  end else if (timeout) begin
                     state  <= FAULT;
                     locked <= 1'b0;
                     fault  <= 1'b1;
                     stuck  <= 1'b1;
                  end
               end
               default: ; // FAULT holds until clear
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpu_clock_monitor.sv
// tb_gpu_clock_monitor
//   Directed bench for gpu_clock_monitor. Stimulus pushes the expected
//   measurement for each non-first rise into a queue; a monitor pops and
//   compares on every period_valid. Status bits are checked directly.
module tb_gpu_clock_monitor;

   localparam int CNT_W = 5;

   logic             clk_in = 1'b0;
   logic             rst    = 1'b1;
   logic             mon_clk = 1'b0;
   logic             clear  = 1'b0;
   logic             locked, fault, stuck, period_valid;
   logic [CNT_W-1:0] period, high_time;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int p;
      int h;
      bit lk;
      bit ft;
   } exp_t;
   exp_t q[$];

   gpu_clock_monitor dut (
      .clk_in       (clk_in),
      .rst          (rst),
      .mon_clk      (mon_clk),
      .clear        (clear),
      .locked       (locked),
      .fault        (fault),
      .stuck        (stuck),
      .period_valid (period_valid),
      .period       (period),
      .high_time    (high_time)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk_in) begin
      if (!rst && period_valid) begin
         if (q.size() == 0) begin
            check("unexpected_period_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("meas_period", int'(period), e.p);
            check("meas_high_time", int'(high_time), e.h);
            check("meas_locked", int'(locked), int'(e.lk));
            check("meas_fault", int'(fault), int'(e.ft));
         end
      end
   end

   // One mon_clk period (high h, low l); optionally expect a measurement
   // of the previous period on this rise.
   task automatic mon_cyc(input int h, input int l, input bit meas,
                          input int ep, input int eh, input bit lk, input bit ft);
      exp_t e;
      if (meas) begin
         e.p = ep; e.h = eh; e.lk = lk; e.ft = ft;
         q.push_back(e);
      end
      mon_clk = 1'b1;
      repeat (h) @(negedge clk_in);
      mon_clk = 1'b0;
      repeat (l) @(negedge clk_in);
   endtask

   task automatic lock_seq();
      mon_cyc(2, 2, 1'b0, 0, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++)
         mon_cyc(2, 2, 1'b1, 4, 2, (i == 4), 1'b0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk_in);
      clear = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic check_status(input string tag, input bit lk, input bit ft, input bit sk);
      check({tag, "_locked"}, int'(locked), int'(lk));
      check({tag, "_fault"}, int'(fault), int'(ft));
      check({tag, "_stuck"}, int'(stuck), int'(sk));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk_in);
      check_status("reset", 1'b0, 1'b0, 1'b0);
      check("reset_period_valid", int'(period_valid), 0);
      check("reset_period", int'(period), 0);
      check("reset_high_time", int'(high_time), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk_in);

      // Test 1: /4, 50% duty -> lock on 4th measurement
      lock_seq();
      mon_cyc(2, 2, 1'b1, 4, 2, 1'b1, 1'b0);
      mon_cyc(2, 2, 1'b1, 4, 2, 1'b1, 1'b0);
      check_status("t1", 1'b1, 1'b0, 1'b0);
      do_clear();
      check_status("t1_clear", 1'b0, 1'b0, 1'b0);

      // Test 2: /6 never locks; clock stop in ACQUIRE quietly returns to IDLE
      mon_cyc(3, 3, 1'b0, 0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         mon_cyc(3, 3, 1'b1, 6, 3, 1'b0, 1'b0);
      repeat (30) @(negedge clk_in);
      check_status("t2", 1'b0, 1'b0, 1'b0);

      // Test 3: stretched period while locked -> sticky fault
      lock_seq();
      mon_cyc(3, 2, 1'b1, 4, 2, 1'b1, 1'b0);
      mon_cyc(2, 2, 1'b1, 5, 3, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         repeat (20) @(negedge clk_in);
         check_status("t3_hold", 1'b0, 1'b1, 1'b0);
      end
      do_clear();
      check_status("t3_clear", 1'b0, 1'b0, 1'b0);
      check("t3_period_kept", int'(period), 5);
      check("t3_high_kept", int'(high_time), 3);

      // Test 4: clock stops while locked -> fault + stuck after timeout
      lock_seq();
      mon_cyc(2, 2, 1'b1, 4, 2, 1'b1, 1'b0);
      repeat (8) @(negedge clk_in);
      check_status("t4_early", 1'b1, 1'b0, 1'b0);
      repeat (12) @(negedge clk_in);
      check_status("t4_stuck", 1'b0, 1'b1, 1'b1);

      // Test 5: clear coincident with a rise detect wins; rise is discarded
      mon_clk = 1'b1;
      @(negedge clk_in);
      @(negedge clk_in);
      clear = 1'b1;
      @(negedge clk_in);
      clear = 1'b0;
      mon_clk = 1'b0;
      check_status("t5_clear", 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk_in);
      lock_seq();
      check_status("t5_relock", 1'b1, 1'b0, 1'b0);

      // Test 6: asynchronous reset mid-period while locked
      mon_cyc(2, 2, 1'b1, 4, 2, 1'b1, 1'b0);
      mon_clk = 1'b1;
      @(negedge clk_in);
      #2 rst = 1'b1;
      #1;
      check("t6_async_locked", int'(locked), 0);
      check("t6_async_period", int'(period), 0);
      check("t6_async_high", int'(high_time), 0);
      @(negedge clk_in);
      mon_clk = 1'b0;
      repeat (3) @(negedge clk_in);
      rst = 1'b0;
      repeat (4) @(negedge clk_in);
      lock_seq();
      check_status("t6_relock", 1'b1, 1'b0, 1'b0);

      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
